codec_cfg_scheduler: RTL and testbench
======================================

Name: codec_cfg_scheduler

Overview:
Owns the single I2C register-write engine that configures the audio codec and shares it between the power-up boot sequence and NREQ runtime requesters, such as volume, mute and input-select controls. After reset it replays a fixed 9-word boot table, then grants the engine to requesters round-robin. It retries NACKed or timed-out writes and enforces a minimum idle gap between bus transactions. It sits between the control logic and the I2C write engine, next to the FIR datapath.

Parameters:
NREQ, 3, number of runtime requesters (1..8)
MAX_RETRY, 3, extra attempts after a NACK/timeout before giving up (0..7)
GAP_CYCLES, 64, minimum clock50 cycles between eng_done and next eng_start (>=1)
TIMEOUT, 65535, cycles from eng_start without eng_done before the attempt counts as failed (<2^20)

Ports:
clock50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester write request, level; hold until ack or err
req_word  in  16*NREQ  requester i word at [16i+15:16i]; {reg_addr[6:0], data[8:0]}
ack  out  NREQ  one-cycle pulse: requester's write completed with ACK
err  out  NREQ  one-cycle pulse: requester's write failed after all retries
eng_start  out  1  one-cycle pulse launching one engine write
eng_word  out  16  word for the engine, stable from eng_start until eng_done
eng_busy  in  1  engine transaction in progress (diagnostic only, not used for sequencing)
eng_done  in  1  one-cycle pulse, transaction finished
eng_nack  in  1  sampled with eng_done; 1 = codec did not ACK
boot_done  out  1  boot table written successfully; stays high until reset
fault  out  1  boot entry exhausted retries; stays high until reset

Behaviour:
- Reset, sampled on clock50: all outputs 0, eng_word=0, state BOOT_ISSUE, boot index=0, retry count=0, round-robin pointer=NREQ-1, gap and timeout counters=0.
- Boot table (index 0..8): 1E00, 0C00, 0A00, 0E53, 0814, 0579, 0117, 1000, 1201 (hex).
- States:
  - BOOT_ISSUE: eng_word<=table[idx], eng_start pulse, go to BOOT_WAIT.
  - BOOT_WAIT: on eng_done with !eng_nack, idx++ and retry count=0. Whether it ACKed or failed, go to GAP. After the ACK of idx 8, set boot_done and make GAP return to IDLE.
  - BOOT_WAIT failure (NACK or timeout): if retry count<MAX_RETRY, retry count++, then GAP, then BOOT_ISSUE with the same idx. Otherwise go to FAULT.
  - FAULT: fault=1. Stays in FAULT until reset, ignores req, issues no eng_start.
  - IDLE: if any req bit is set, pick the first set bit searching from pointer+1 modulo NREQ. Latch that requester's word into eng_word, set pointer to the winner, pulse eng_start in the next cycle, go to WAIT.
  - WAIT: on eng_done with !eng_nack, pulse ack[winner] in the same cycle the done is registered, then GAP. On failure with retries remaining, retry count++, GAP, reissue the latched word; req is not re-sampled. On failure with retries exhausted, pulse err[winner], then GAP.
  - GAP: count GAP_CYCLES, then go to the next state (BOOT_ISSUE or IDLE). Clear retry count when leaving for a new word.
- Timeout: the counter clears at eng_start and increments in the WAIT states. Reaching TIMEOUT equals a NACK. Any later stray eng_done is ignored.
- eng_done in any state other than BOOT_WAIT/WAIT is ignored.
- req is ignored before boot_done. A requester dropping req after grant does not abort the write; ack/err still pulse.
- A requester re-asserting req immediately after its ack is granted again only after every other pending requester has been served (fairness).
- Latency:
  - IDLE with req seen to eng_start: 2 cycles.
  - eng_done to ack: 1 cycle.
  - eng_done to next eng_start: GAP_CYCLES+1 cycles minimum.
- At most one of ack/err bits is high at any time; never together with eng_start.
- Reset mid-transaction: the state machine returns to BOOT_ISSUE and reboots fully. The engine is reset by the same reset.

Test Plan:
1. Reset, engine model ACKs all writes after 40 cycles -> 9 eng_start pulses with words 1E00..1201 in order, consecutive starts ≥ GAP_CYCLES+41 apart, then boot_done=1, fault=0.
2. Boot with idx 3 NACKed twice then ACKed -> 0E53 issued 3 times, sequence continues to 1201, boot_done=1. Same test with 4 NACKs -> fault=1 after the 4th attempt, no further eng_start, req ignored.
3. After boot, req=3'b111 held continuously with words 0579/0117/0A08 -> grants in order 0,1,2,0,1,2; each ack pulses exactly once, 1 cycle after the matching eng_done.
4. req[1] NACKed MAX_RETRY+1 times -> 4 eng_start of its word, err[1] pulse only, no ack[1]. The next grant goes to requester 2.
5. Engine never returns eng_done (TIMEOUT=100) -> retry at 100+GAP_CYCLES+1 cycles; after 4 attempts err pulses. A late eng_done during GAP produces no ack.
6. Assert reset during requester WAIT -> outputs clear the next cycle, boot restarts at 1E00, boot_done=0, the pending request is not acked.

Source files
------------

// File: rtl/codec_cfg_scheduler.sv
// codec_cfg_scheduler: shares the single I2C write engine between the codec
// boot table and NREQ runtime requesters, with retry, timeout and idle gap.
module codec_cfg_scheduler #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 64,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                 clock50,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_word,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic                 eng_start,
    output logic [15:0]          eng_word,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic                 eng_nack,
    output logic                 boot_done,
    output logic                 fault
);

    localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TW        = 20;
    localparam int unsigned RW        = 3;
    localparam int unsigned IW        = 4;
    localparam int unsigned BOOT_LAST = 8;

    typedef enum logic [2:0] {
        BOOT_ISSUE,
        BOOT_WAIT,
        GAP,
        FAULT,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // Where GAP hands over once the idle gap has elapsed.
    typedef enum logic [1:0] {
        DST_BOOT,
        DST_REQ,
        DST_IDLE
    } dst_t;

    state_t          state, state_d;
    dst_t            dst, dst_d;
    logic [IW-1:0]   idx, idx_d;
    logic [RW-1:0]   rcnt, rcnt_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [GW-1:0]   gcnt, gcnt_d;
    logic [TW-1:0]   tcnt, tcnt_d;
    logic [15:0]     word_d;
    logic            start_d;
    logic [NREQ-1:0] ack_d, err_d;
    logic            boot_done_d, fault_d;

    logic            done_ok, failed, retry_left, gap_over;
    logic            found;
    logic [PW-1:0]   sel;
    logic [15:0]     sel_word;

    // The engine busy flag is diagnostic only; sequencing relies on eng_done.
    logic unused_busy;
    assign unused_busy = eng_busy;

    function automatic logic [15:0] boot_word(input logic [IW-1:0] i);
        case (i)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0C00;
            4'd2:    return 16'h0A00;
            4'd3:    return 16'h0E53;
            4'd4:    return 16'h0814;
            4'd5:    return 16'h0579;
            4'd6:    return 16'h0117;
            4'd7:    return 16'h1000;
            4'd8:    return 16'h1201;
            default: return 16'h0000;
        endcase
    endfunction

    // Transaction outcome: an ACKed done, or a NACK / timeout counts as failure.
    always_comb begin
        done_ok    = eng_done && !eng_nack;
        failed     = (eng_done && eng_nack) || (!eng_done && (tcnt == TW'(TIMEOUT)));
        retry_left = (rcnt < RW'(MAX_RETRY));
        gap_over   = (gcnt == GW'(GAP_CYCLES - 1));
    end

    // Round-robin search starting just after the last winner, plus its word.
    always_comb begin
        found    = 1'b0;
        sel      = ptr;
        sel_word = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (!found && req[(int'(ptr) + k) % int'(NREQ)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % int'(NREQ));
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            if (sel == PW'(k)) begin
                sel_word = req_word[16*k +: 16];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        dst_d       = dst;
        idx_d       = idx;
        rcnt_d      = rcnt;
        ptr_d       = ptr;
        gcnt_d      = gcnt;
        tcnt_d      = tcnt;
        word_d      = eng_word;
        start_d     = 1'b0;
        ack_d       = '0;
        err_d       = '0;
        boot_done_d = boot_done;
        fault_d     = fault;

        case (state)
            BOOT_ISSUE: begin
                word_d  = boot_word(idx);
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = BOOT_WAIT;
            end

            BOOT_WAIT: begin
                tcnt_d = tcnt + TW'(1);
                if (done_ok) begin
                    rcnt_d  = '0;
                    gcnt_d  = '0;
                    state_d = GAP;
                    if (idx == IW'(BOOT_LAST)) begin
                        boot_done_d = 1'b1;
                        dst_d       = DST_IDLE;
                    end else begin
                        idx_d = idx + IW'(1);
                        dst_d = DST_BOOT;
                    end
                end else if (failed) begin
                    if (retry_left) begin
                        rcnt_d  = rcnt + RW'(1);
                        gcnt_d  = '0;
                        dst_d   = DST_BOOT;
                        state_d = GAP;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end

            // The last gap cycle launches the next write directly so that
            // done-to-start is exactly GAP_CYCLES+1.
            GAP: begin
                if (gap_over) begin
                    case (dst)
                        DST_BOOT: begin
                            word_d  = boot_word(idx);
                            start_d = 1'b1;
                            tcnt_d  = '0;
                            state_d = BOOT_WAIT;
                        end
                        DST_REQ: begin
                            start_d = 1'b1;
                            tcnt_d  = '0;
                            state_d = WAIT;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    gcnt_d = gcnt + GW'(1);
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            IDLE: begin
                if (found) begin
                    ptr_d   = sel;
                    word_d  = sel_word;
                    rcnt_d  = '0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = WAIT;
            end

            WAIT: begin
                tcnt_d = tcnt + TW'(1);
                if (done_ok) begin
                    ack_d   = NREQ'(1) << ptr;
                    rcnt_d  = '0;
                    gcnt_d  = '0;
                    dst_d   = DST_IDLE;
                    state_d = GAP;
                end else if (failed) begin
                    gcnt_d  = '0;
                    state_d = GAP;
                    if (retry_left) begin
                        rcnt_d = rcnt + RW'(1);
                        dst_d  = DST_REQ;
                    end else begin
                        err_d  = NREQ'(1) << ptr;
                        rcnt_d = '0;
                        dst_d  = DST_IDLE;
                    end
                end
            end

            default: begin
                state_d = BOOT_ISSUE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clock50) begin
        if (reset) begin
            state     <= BOOT_ISSUE;
            dst       <= DST_BOOT;
            idx       <= '0;
            rcnt      <= '0;
            ptr       <= PW'(NREQ - 1);
            gcnt      <= '0;
            tcnt      <= '0;
            eng_word  <= '0;
            eng_start <= 1'b0;
            ack       <= '0;
            err       <= '0;
            boot_done <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            dst       <= dst_d;
            idx       <= idx_d;
            rcnt      <= rcnt_d;
            ptr       <= ptr_d;
            gcnt      <= gcnt_d;
            tcnt      <= tcnt_d;
            eng_word  <= word_d;
            eng_start <= start_d;
            ack       <= ack_d;
            err       <= err_d;
            boot_done <= boot_done_d;
            fault     <= fault_d;
        end
    end

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// Bench for codec_cfg_scheduler: plays the I2C engine and the requesters,
// predicting grants, words and responses from a behavioural model.
module tb_codec_cfg_scheduler;

    localparam int NREQ      = 3;
    localparam int MAX_RETRY = 3;
    localparam int GAP       = 8;
    localparam int TMO       = 100;

    logic                 clock50 = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_word;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic                 eng_start;
    logic [15:0]          eng_word;
    logic                 eng_busy;
    logic                 eng_done;
    logic                 eng_nack;
    logic                 boot_done;
    logic                 fault;

    int tests    = 0;
    int failed   = 0;
    int cyc      = 0;
    int n_starts = 0;
    int n_acks   = 0;

    logic [15:0]     boot_tab [9] = '{16'h1E00, 16'h0C00, 16'h0A00, 16'h0E53, 16'h0814,
                                      16'h0579, 16'h0117, 16'h1000, 16'h1201};
    logic [15:0]     m_word [NREQ];
    logic [NREQ-1:0] pend;
    int              m_ptr;
    int              first_sc;

    codec_cfg_scheduler #(
        .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clock50(clock50), .reset(reset), .req(req), .req_word(req_word),
        .ack(ack), .err(err), .eng_start(eng_start), .eng_word(eng_word),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
        .boot_done(boot_done), .fault(fault)
    );

    always #10 clock50 = ~clock50;

    always @(posedge clock50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses are mutually exclusive: at most one of ack/err/eng_start at a time.
    always @(posedge clock50) begin
        #1;
        if (eng_start) n_starts++;
        if (|ack) n_acks++;
        if (eng_start || (|ack) || (|err))
            chk("pulse_exclusive", 32'($countones({ack, err, eng_start})), 32'd1);
    end

    task automatic tick();
        @(posedge clock50);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic apply_req();
        req = pend;
        for (int i = 0; i < NREQ; i++) req_word[16*i +: 16] = m_word[i];
    endtask

    // Engine model: wait for a start, optionally answer after lat cycles.
    // Returns one cycle after the done pulse (or at the start if no done).
    task automatic serve(input bit give_done, input bit nack, input int lat,
                         output logic [15:0] word, output int sc, output int dc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!eng_start && n < 3000);
        chk("eng_start_seen", 32'(eng_start), 32'd1);
        word = eng_word;
        sc   = cyc;
        dc   = cyc;
        if (give_done) begin
            repeat (lat) tick();
            chk("eng_word_stable", 32'(eng_word), 32'(word));
            eng_done = 1'b1;
            eng_nack = nack;
            dc       = cyc;
            tick();
            eng_done = 1'b0;
            eng_nack = 1'b0;
        end
    endtask

    task automatic run_boot(input int bad_idx, input int bad_nacks);
        int          prev, sc, dc, nk;
        logic [15:0] w;
        prev = -1;
        for (int i = 0; i < 9; i++) begin
            nk = (i == bad_idx) ? bad_nacks : 0;
            for (int a = 0; a <= MAX_RETRY && a <= nk; a++) begin
                serve(1'b1, a < nk, 40, w, sc, dc);
                chk("boot_word", 32'(w), 32'(boot_tab[i]));
                if (prev >= 0) chk("boot_start_spacing", 32'((sc - prev) >= GAP + 41), 32'd1);
                prev = sc;
                if (a == MAX_RETRY && a < nk) begin
                    chk("boot_fault_set", 32'(fault), 32'd1);
                    chk("boot_fault_no_done", 32'(boot_done), 32'd0);
                    return;
                end
            end
        end
        chk("boot_done_set", 32'(boot_done), 32'd1);
        chk("boot_no_fault", 32'(fault), 32'd0);
    endtask

    task automatic do_txn(input int nacks, input bit hold);
        int          w, sc, dc, prev_dc, tries, r;
        logic [15:0] wd;
        w       = rr_pick(pend, m_ptr);
        tries   = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
        prev_dc = -1;
        for (int a = 0; a < tries; a++) begin
            serve(1'b1, a < nacks, $urandom_range(1, 30), wd, sc, dc);
            if (a == 0) first_sc = sc;
            chk("grant_word", 32'(wd), 32'(m_word[w]));
            if (prev_dc >= 0) chk("retry_spacing", 32'((sc - prev_dc) >= GAP + 1), 32'd1);
            prev_dc = dc;
            if (a == tries - 1) begin
                chk("ack_vec", 32'(ack), (nacks <= MAX_RETRY) ? 32'(1 << w) : 32'd0);
                chk("err_vec", 32'(err), (nacks > MAX_RETRY) ? 32'(1 << w) : 32'd0);
            end else begin
                chk("no_resp_on_retry", 32'({ack, err}), 32'd0);
            end
        end
        tick();
        chk("resp_one_cycle", 32'({ack, err}), 32'd0);
        m_ptr = w;
        if (!hold) begin
            pend[w] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    m_word[i] = 16'($urandom);
                end
            end
        end
        if (pend == '0) begin
            r         = $urandom_range(0, NREQ - 1);
            pend[r]   = 1'b1;
            m_word[r] = 16'($urandom);
        end
        apply_req();
    endtask

    task automatic do_timeout_txn();
        int          w, sc, dc, prev, n;
        logic [15:0] wd;
        w    = rr_pick(pend, m_ptr);
        prev = -1;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            serve(1'b0, 1'b0, 1, wd, sc, dc);
            chk("tmo_word", 32'(wd), 32'(m_word[w]));
            if (prev >= 0) chk("tmo_retry_spacing", 32'(sc - prev), 32'(TMO + GAP + 1));
            prev = sc;
        end
        n = 0;
        while (err == '0 && n < TMO + 20) begin
            tick();
            n++;
        end
        chk("tmo_err_vec", 32'(err), 32'(1 << w));
        chk("tmo_err_latency", 32'(cyc - prev), 32'(TMO + 1));
        chk("tmo_no_ack", 32'(ack), 32'd0);
        eng_done = 1'b1;
        eng_nack = 1'b0;
        tick();
        eng_done = 1'b0;
        chk("stray_done_ignored", 32'({ack, err}), 32'd0);
        m_ptr = w;
    endtask

    initial begin
        int          c, na, ns, sc, dc;
        logic [15:0] wd;
        reset    = 1'b1;
        req      = '0;
        req_word = '0;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        eng_nack = 1'b0;
        pend     = '0;
        m_ptr    = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_word[i] = 16'h0;
        repeat (3) tick();

        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_eng_word", 32'(eng_word), 32'd0);
        chk("rst_ack_err", 32'({ack, err}), 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        // Clean boot, then first request latency and round-robin with req held.
        run_boot(-1, 0);
        repeat (GAP + 10) tick();
        for (int i = 0; i < NREQ; i++) m_word[i] = 16'($urandom);
        pend = '1;
        apply_req();
        c = cyc;
        do_txn(0, 1'b1);
        chk("req_to_start_latency", 32'(first_sc - c), 32'd2);
        for (int t = 0; t < 5; t++) do_txn(0, 1'b1);

        // Requester 1 exhausts its retries; requester 2 goes next.
        pend[0] = 1'b0;
        apply_req();
        do_txn(MAX_RETRY + 1, 1'b1);
        do_txn(0, 1'b1);

        // Engine silent: timeouts drive the retries.
        do_timeout_txn();

        // Randomized traffic with random NACK counts.
        for (int t = 0; t < 12; t++) do_txn($urandom_range(0, 5), 1'b0);

        // Reset during a requester transaction, reboot with two NACKs at idx 3.
        serve(1'b0, 1'b0, 1, wd, sc, dc);
        repeat (5) tick();
        reset = 1'b1;
        pend  = '0;
        apply_req();
        na = n_acks;
        tick();
        chk("midrst_eng_start", 32'(eng_start), 32'd0);
        chk("midrst_eng_word", 32'(eng_word), 32'd0);
        chk("midrst_ack_err", 32'({ack, err}), 32'd0);
        chk("midrst_boot_done", 32'(boot_done), 32'd0);
        reset = 1'b0;
        run_boot(3, 2);
        chk("midrst_no_ack", 32'(n_acks), 32'(na));

        // Boot entry NACKed past the retry limit: fault, then requests ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_boot(3, MAX_RETRY + 1);
        pend = '1;
        apply_req();
        ns = n_starts;
        na = n_acks;
        repeat (300) tick();
        chk("fault_no_start", 32'(n_starts), 32'(ns));
        chk("fault_no_ack", 32'(n_acks), 32'(na));
        chk("fault_sticky", 32'(fault), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
